// File: rtl/icache_refill_pkg.sv
// Shared definitions for the instruction-cache refill engine: FSM encoding,
// line geometry defaults kept in common with the cache, and RAM bus width.
package icache_refill_pkg;

    localparam int unsigned BLOCK_WIDTH_DEF = 4;
    localparam int unsigned BLOCK_SIZE_DEF  = 2 ** BLOCK_WIDTH_DEF;
    localparam int unsigned RAM_BUS_WIDTH   = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FETCH,
        DONE
    } refillState_t;

endpackage

// File: rtl/icache_refill.sv
// Instruction-cache refill engine: on a miss, wins the RAM port, streams the
// block in one byte per cycle and strobes the assembled line to the cache.
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int unsigned BLOCK_WIDTH = BLOCK_WIDTH_DEF,
    parameter int unsigned BLOCK_SIZE  = 2 ** BLOCK_WIDTH
) (
    input  logic                                  clkIn,
    input  logic                                  resetIn,
    input  logic                                  clearIn,
    input  logic                                  missIn,
    input  logic [31:0]                           instrAddrIn,
    input  logic                                  busGrant,
    input  logic [RAM_BUS_WIDTH-1:0]              ramDataIn,
    output logic                                  busReq,
    output logic [31:0]                           ramAddr,
    output logic                                  ramWr,
    output logic                                  memDataValid,
    output logic [31-BLOCK_WIDTH:0]               memAddr,
    output logic [BLOCK_SIZE*RAM_BUS_WIDTH-1:0]   memDataOut,
    output logic                                  busy
);

    localparam int unsigned BLK_W  = 32 - BLOCK_WIDTH;
    localparam int unsigned CNT_W  = BLOCK_WIDTH + 1;
    localparam int unsigned LINE_W = BLOCK_SIZE * RAM_BUS_WIDTH;

    refillState_t           state;
    refillState_t           nextState;
    logic [BLK_W-1:0]       blk;
    logic [CNT_W-1:0]       issueCnt;
    logic [BLOCK_WIDTH-1:0] recvCnt;
    logic                   pending;
    logic [LINE_W-1:0]      lineBuf;
    logic [LINE_W-1:0]      lineNext;
    logic                   issueNow;
    logic                   captureNow;
    logic                   lastByte;

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // A clear in FETCH suppresses both the capture and any further issue.
    assign captureNow = (state == FETCH) && pending && !clearIn;
    assign lastByte   = captureNow && (&recvCnt);

    always_comb begin
        nextState    = state;
        busReq       = 1'b0;
        ramAddr      = '0;
        issueNow     = 1'b0;
        memDataValid = 1'b0;
        case (state)
            IDLE: begin
                if (missIn && !clearIn) begin
                    nextState = REQ;
                end
            end
            REQ: begin
                busReq = 1'b1;
                if (clearIn) begin
                    nextState = IDLE;
                end else if (busGrant) begin
                    nextState = FETCH;
                end
            end
            FETCH: begin
                busReq = 1'b1;
                if (clearIn) begin
                    nextState = IDLE;
                end else begin
                    if (!issueCnt[BLOCK_WIDTH]) begin
                        issueNow = 1'b1;
                        ramAddr  = {blk, issueCnt[BLOCK_WIDTH-1:0]};
                    end
                    if (lastByte) begin
                        nextState = DONE;
                    end
                end
            end
            DONE: begin
                memDataValid = 1'b1;
                nextState    = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_comb begin
        lineNext = lineBuf;
        lineNext[recvCnt*RAM_BUS_WIDTH +: RAM_BUS_WIDTH] = ramDataIn;
    end

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            blk        <= '0;
            issueCnt   <= '0;
            recvCnt    <= '0;
            pending    <= 1'b0;
            lineBuf    <= '0;
            memAddr    <= '0;
            memDataOut <= '0;
        end else begin
            if ((state == IDLE) && (nextState == REQ)) begin
                blk <= BLK_W'(instrAddrIn >> BLOCK_WIDTH);
            end
            if (state == REQ) begin
                issueCnt <= '0;
                recvCnt  <= '0;
            end
            pending <= issueNow;
            if (issueNow) begin
                issueCnt <= issueCnt + CNT_W'(1);
            end
            if (captureNow) begin
                lineBuf <= lineNext;
                recvCnt <= recvCnt + BLOCK_WIDTH'(1);
            end
            // The output copy takes the merged final byte so DONE needs no extra cycle.
            if (lastByte) begin
                memAddr    <= blk;
                memDataOut <= lineNext;
            end
        end
    end

    assign ramWr = 1'b0;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_icache_refill.sv
// Scoreboard bench for icache_refill: stimulus queues expected line strobes,
// a negedge monitor pops and compares them; per-cycle bus checks run inline.
module tb_icache_refill;

    logic         clkIn = 1'b0;
    logic         resetIn;
    logic         clearIn;
    logic         missIn;
    logic [31:0]  instrAddrIn;
    logic         busGrant;
    logic [7:0]   ramDataIn = 8'h00;
    logic         busReq;
    logic [31:0]  ramAddr;
    logic         ramWr;
    logic         memDataValid;
    logic [27:0]  memAddr;
    logic [127:0] memDataOut;
    logic         busy;

    int unsigned  cyc = 0;
    int           vectors = 0;
    int           miscompares = 0;

    typedef struct {
        int unsigned  cyc;
        logic [27:0]  addr;
        logic [127:0] line;
    } exp_t;

    exp_t expQ[$];

    icache_refill #(.BLOCK_WIDTH(4)) dut (
        .clkIn        (clkIn),
        .resetIn      (resetIn),
        .clearIn      (clearIn),
        .missIn       (missIn),
        .instrAddrIn  (instrAddrIn),
        .busGrant     (busGrant),
        .ramDataIn    (ramDataIn),
        .busReq       (busReq),
        .ramAddr      (ramAddr),
        .ramWr        (ramWr),
        .memDataValid (memDataValid),
        .memAddr      (memAddr),
        .memDataOut   (memDataOut),
        .busy         (busy)
    );

    always #5 clkIn = ~clkIn;

    // RAM returns the low address byte one cycle after the address.
    always @(posedge clkIn) begin
        cyc       <= cyc + 1;
        ramDataIn <= ramAddr[7:0];
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clkIn) begin : monitor
        exp_t e;
        if (memDataValid === 1'b1) begin
            if (expQ.size() == 0) begin
                chk("unexpectedStrobe", 128'(memAddr), 128'h0);
                chk("unexpectedStrobeFlag", 128'(memDataValid), 128'h0);
            end else begin
                e = expQ.pop_front();
                chk("strobeCycle", 128'(cyc), 128'(e.cyc));
                chk("memAddr", 128'(memAddr), 128'(e.addr));
                chk("memDataOut", memDataOut, e.line);
            end
        end
    end

    // gd: grant delay in cycles; clrCyc: cycle clearIn is sampled (-1 for none).
    task automatic runFill(input logic [31:0] addr, input int gd, input int clrCyc,
                           input logic [127:0] expLine);
        int unsigned base;
        bit          strobe;
        bit          active;
        logic [31:0] ea;
        strobe = (clrCyc < 0) || (clrCyc >= 19 + gd);
        for (int t = 0; t <= 21 + gd; t++) begin
            @(negedge clkIn);
            if (t == 0) begin
                base = cyc;
                if (strobe) expQ.push_back('{base + 19 + gd, addr[31:4], expLine});
            end
            active = (clrCyc < 0) || (t <= clrCyc);
            ea = '0;
            if (active && t >= 2 + gd && t <= 17 + gd) ea = {addr[31:4], 4'(t - 2 - gd)};
            chk("ramAddr", 128'(ramAddr), 128'(ea));
            chk("busReq", 128'(busReq), 128'(active && t >= 1 && t <= 18 + gd));
            chk("busy", 128'(busy), 128'(active && t >= 1 && t <= 19 + gd));
            missIn      = (t == 0);
            instrAddrIn = addr;
            busGrant    = (t >= 1 + gd);
            clearIn     = (t == clrCyc);
        end
        missIn   = 1'b0;
        busGrant = 1'b0;
        clearIn  = 1'b0;
    endtask

    task automatic resetMidFetch();
        int unsigned base;
        logic [31:0] ea;
        for (int t = 0; t <= 32; t++) begin
            @(negedge clkIn);
            if (t == 0) begin
                base = cyc;
                expQ.push_back('{base + 30, 28'h0000345, 128'h5F5E5D5C5B5A59585756555453525150});
            end
            if (t == 10) chk("rstPreAddr", 128'(ramAddr), 128'h3458);
            if (t == 11) begin
                chk("rstBusReq", 128'(busReq), 128'h0);
                chk("rstRamAddr", 128'(ramAddr), 128'h0);
                chk("rstRamWr", 128'(ramWr), 128'h0);
                chk("rstValid", 128'(memDataValid), 128'h0);
                chk("rstMemAddr", 128'(memAddr), 128'h0);
                chk("rstMemData", memDataOut, 128'h0);
                chk("rstBusy", 128'(busy), 128'h0);
            end
            if (t == 12) begin
                chk("reReqBusReq", 128'(busReq), 128'h1);
                chk("reReqAddr", 128'(ramAddr), 128'h0);
            end
            if (t >= 13 && t <= 28) begin
                ea = {28'h0000345, 4'(t - 13)};
                chk("reFetchAddr", 128'(ramAddr), 128'(ea));
            end
            missIn      = (t < 30);
            instrAddrIn = 32'h0000_3450;
            busGrant    = (t >= 1);
            clearIn     = 1'b0;
            resetIn     = (t == 10);
        end
        missIn   = 1'b0;
        busGrant = 1'b0;
    endtask

    initial begin : timeout
        #100000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        resetIn     = 1'b1;
        clearIn     = 1'b0;
        missIn      = 1'b0;
        busGrant    = 1'b0;
        instrAddrIn = '0;
        repeat (3) @(negedge clkIn);
        chk("resetBusReq", 128'(busReq), 128'h0);
        chk("resetRamAddr", 128'(ramAddr), 128'h0);
        chk("resetRamWr", 128'(ramWr), 128'h0);
        chk("resetValid", 128'(memDataValid), 128'h0);
        chk("resetMemAddr", 128'(memAddr), 128'h0);
        chk("resetMemData", memDataOut, 128'h0);
        chk("resetBusy", 128'(busy), 128'h0);
        resetIn = 1'b0;

        runFill(32'h0000_1234, 0, -1, 128'h3F3E3D3C3B3A39383736353433323130);
        runFill(32'h0000_1234, 5, -1, 128'h3F3E3D3C3B3A39383736353433323130);
        runFill(32'h0000_5670, 0, 8, 128'h0);
        runFill(32'h0000_2000, 0, -1, 128'h0F0E0D0C0B0A09080706050403020100);

        @(negedge clkIn);
        missIn      = 1'b1;
        clearIn     = 1'b1;
        instrAddrIn = 32'h0000_4440;
        for (int i = 0; i < 3; i++) begin
            @(negedge clkIn);
            chk("clrMissBusReq", 128'(busReq), 128'h0);
            chk("clrMissBusy", 128'(busy), 128'h0);
            missIn  = 1'b0;
            clearIn = 1'b0;
        end

        runFill(32'h0000_ABC0, 0, 19, 128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0);
        resetMidFetch();

        @(negedge clkIn);
        chk("pendingStrobes", 128'(expQ.size()), 128'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
